seg_display_port: RTL and testbench
===================================

// Module: seg_display_port
// PURPOSE
//  Memory-mapped 8-digit seven-segment driver on the CPU data bus, beside the data RAM.
//  Same slave handshake as the data RAM (enable, write-enable, word address, combinational read).
//  Holds value, decimal-point, digit-enable and control registers.
//  Scans one digit at a time, with a frame-synchronous shadow copy so the display never tears.
// PARAMETERS
//  CLK_DIV_BITS  16  clock cycles per digit = 2**CLK_DIV_BITS
//  DIGITS        8   digits scanned, 1..8; digit i shows VALUE[4i+3:4i]
//  ACTIVE_LOW    1   1: seg and an are driven low-active; 0: high-active
// PORTS
//  clk       in   1        single clock, all state updates on posedge
//  rst       in   1        synchronous, active-high reset
//  seg_ena   in   1        bus select for this slave
//  wena      in   1        write enable; qualified by seg_ena
//  addr      in   2        register index: 0 VALUE, 1 DP, 2 EN, 3 CTRL
//  data_in   in   32       write data
//  data_out  out  32       combinational read of register[addr]; unused bits read 0
//  seg       out  8        segments: bit0 = a ... bit6 = g, bit7 = dp (registered)
//  an        out  DIGITS   digit anodes; one-hot active (registered)
// BEHAVIOUR
//  - Registers: VALUE[31:0], DP[7:0], EN[7:0], CTRL[1:0] (bit0 = blank_all, bit1 = blink_en).
//  - Write: a posedge with seg_ena & wena writes data_in to register[addr], masked to its width.
//    The new value reads back on the next cycle.
//  - Read: data_out = register[addr], zero-extended. It is independent of seg_ena and adds no cycle.
//    addr 3 returns {24'b0, frame_cnt[4], idx[2:0], 2'b0, CTRL[1:0]}.
//  - Scan: div_cnt (CLK_DIV_BITS bits) increments every cycle.
//    When div_cnt is all ones, idx advances: idx = (idx == DIGITS-1) ? 0 : idx + 1.
//  - Frame wrap = the cycle idx goes DIGITS-1 -> 0. On that same edge:
//    - VALUE, DP and EN are copied to shadow registers.
//    - frame_cnt (5 bits) increments and wraps 31 -> 0.
//  - Display path uses shadows only. Writes become visible at the first frame wrap after the write.
//    Frame = DIGITS * 2**CLK_DIV_BITS cycles.
//  - A write on the same edge as a frame wrap updates the register. The shadow copies the old value.
//    The new value is shown one frame later.
//  - Output regs are updated every cycle from the current idx (one cycle of latency after an idx change):
//    - lit = EN_sh[idx] & ~CTRL[0] & ~(CTRL[1] & frame_cnt[4]).
//    - an = one-hot(idx) if lit, else all inactive.
//    - seg[6:0] = hex_decode(VALUE_sh nibble idx) if lit, else all inactive.
//    - seg[7] = DP_sh[idx] & lit.
//    - CTRL acts immediately; it is not shadowed.
//  - hex_decode, active-high gfedcba, 0..F:
//    3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//  - Polarity: when ACTIVE_LOW = 1, seg and an are inverted after decode.
//  - Reset clears VALUE, DP, EN, CTRL, all shadows, div_cnt, idx and frame_cnt to 0.
//    seg and an are driven all inactive (8'hFF and all ones when ACTIVE_LOW = 1).
//    A reset mid-frame restarts the scan at digit 0 on the next cycle.
//    A write on the reset edge is ignored.
//  - DIGITS < 8: upper VALUE nibbles and upper DP/EN bits are stored and read back but never displayed.
// TESTING (CLK_DIV_BITS = 2, DIGITS = 8, ACTIVE_LOW = 1; frame = 32 cycles)
//  1. Reset -> an = 8'hFF, seg = 8'hFF, data_out = 0 for addr 0..3; hold them 40 cycles with EN = 0.
//  2. Write VALUE = 32'h12345678, EN = 8'hFF.
//     Before the frame wrap: an stays FF.
//     After the wrap: an = 8'hFE, seg = 8'h80 (digit '8').
//     4 cycles later: an = 8'hFD, seg = 8'hF8 (digit '7').
//  3. Write DP = 8'h01; after the next wrap, digit 0 shows seg = 8'h00.
//     Write CTRL = 1 -> an = FF the cycle after the write lands.
//  4. Write VALUE = 32'hAAAAAAAA on the exact wrap edge.
//     The following frame still shows the old nibbles; the next frame shows 'A' (seg = 8'h88).
//  5. CTRL = 2: an is all ones for frame_cnt 16..31 and scans for 0..15.
//     Readback of addr 3 has bit7 = frame_cnt[4].
//  6. Assert rst mid-frame with idx = 5 -> next cycle an = FF, idx = 0, and all registers read 0.

Source files
------------

// File: rtl/seg_display_port.sv
// Memory-mapped multi-digit seven-segment scanner on the CPU data bus.
// Bus registers are copied to shadows at each frame wrap, so a frame never shows a mix of old and new digits.
module seg_display_port #(
  parameter int CLK_DIV_BITS = 16,
  parameter int DIGITS       = 8,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seg_ena,
  input  logic              wena,
  input  logic [1:0]        addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam logic       POL  = (ACTIVE_LOW != 0);
  localparam logic [2:0] LAST = 3'(DIGITS - 1);

  logic [31:0]             value_r, value_sh;
  logic [7:0]              dp_r, dp_sh, en_r, en_sh;
  logic [1:0]              ctrl_r;
  logic [CLK_DIV_BITS-1:0] div_cnt;
  logic [2:0]              idx;
  logic [4:0]              frame_cnt;

  logic              tick, wrap, lit;
  logic [3:0]        nib;
  logic [7:0]        seg_hi, seg_nxt;
  logic [DIGITS-1:0] an_hi, an_nxt;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0: hex_decode = 7'h3F;  4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;  4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;  4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;  4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;  4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;  4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;  4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;  default: hex_decode = 7'h71;
    endcase
  endfunction

  assign tick = &div_cnt;
  assign wrap = tick && (idx == LAST);

  // CTRL is live (not shadowed) so blanking and blink act without waiting for a frame
  always_comb begin
    lit     = en_sh[idx] & ~ctrl_r[0] & ~(ctrl_r[1] & frame_cnt[4]);
    nib     = value_sh[{idx, 2'b00} +: 4];
    seg_hi  = lit ? {dp_sh[idx], hex_decode(nib)} : 8'h00;
    an_hi   = lit ? (DIGITS'(1) << idx) : '0;
    seg_nxt = seg_hi ^ {8{POL}};
    an_nxt  = an_hi ^ {DIGITS{POL}};
  end

  always_comb begin
    data_out = 32'h0;
    case (addr)
      2'd0: data_out = value_r;
      2'd1: data_out = {24'h0, dp_r};
      2'd2: data_out = {24'h0, en_r};
      default: data_out = {24'h0, frame_cnt[4], idx, 2'b00, ctrl_r};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_r   <= '0;
      dp_r      <= '0;
      en_r      <= '0;
      ctrl_r    <= '0;
      value_sh  <= '0;
      dp_sh     <= '0;
      en_sh     <= '0;
      div_cnt   <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      seg       <= {8{POL}};
      an        <= {DIGITS{POL}};
    end else begin
      if (seg_ena && wena) begin
        case (addr)
          2'd0: value_r <= data_in;
          2'd1: dp_r    <= data_in[7:0];
          2'd2: en_r    <= data_in[7:0];
          default: ctrl_r <= data_in[1:0];
        endcase
      end
      div_cnt <= div_cnt + 1'b1;
      if (tick) idx <= (idx == LAST) ? 3'd0 : idx + 3'd1;
      // shadows sample the pre-edge registers, so a write on the wrap edge waits one more frame
      if (wrap) begin
        value_sh  <= value_r;
        dp_sh     <= dp_r;
        en_sh     <= en_r;
        frame_cnt <= frame_cnt + 5'd1;
      end
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_port.sv
// Directed bench for seg_display_port with a 4-cycle digit period (32-cycle frame).
module tb_seg_display_port;

  logic        clk = 1'b0;
  logic        rst, seg_ena, wena;
  logic [1:0]  addr;
  logic [31:0] data_in, data_out;
  logic [7:0]  seg, an;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  seg_display_port #(.CLK_DIV_BITS(2), .DIGITS(8), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .seg_ena(seg_ena), .wena(wena), .addr(addr),
    .data_in(data_in), .data_out(data_out), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // cyc counts posedges since reset release; checks land 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    chk(tag, data_out, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    seg_ena = 1'b1; wena = 1'b1; addr = a; data_in = d;
    step();
    seg_ena = 1'b0; wena = 1'b0;
  endtask

  initial begin
    rst = 1'b1; seg_ena = 1'b0; wena = 1'b0; addr = 2'd0; data_in = '0;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;

    // 1: reset state, held with EN = 0
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    rd(2'd0, 32'h0, "rst_value");
    rd(2'd1, 32'h0, "rst_dp");
    rd(2'd2, 32'h0, "rst_en");
    rd(2'd3, 32'h0, "rst_ctrl");
    for (int i = 0; i < 40; i++) begin
      step();
      chk("idle_an", {24'h0, an}, 32'hFF);
      chk("idle_seg", {24'h0, seg}, 32'hFF);
    end

    // 2: VALUE/EN appear only after the wrap at edge 64
    wr(2'd0, 32'h12345678);
    wr(2'd2, 32'h000000FF);
    rd(2'd0, 32'h12345678, "rb_value");
    rd(2'd2, 32'h000000FF, "rb_en");
    while (cyc < 64) begin
      step();
      chk("prewrap_an", {24'h0, an}, 32'hFF);
    end
    step();
    chk("d0_an", {24'h0, an}, 32'hFE);
    chk("d0_seg", {24'h0, seg}, 32'h80);
    run_to(69);
    chk("d1_an", {24'h0, an}, 32'hFD);
    chk("d1_seg", {24'h0, seg}, 32'hF8);

    // 3: DP on digit 0 after the wrap at 96, then blank_all
    wr(2'd1, 32'hFFFFFF01);
    rd(2'd1, 32'h01, "rb_dp_masked");
    run_to(96);
    chk("d7_an", {24'h0, an}, 32'h7F);
    chk("d7_seg", {24'h0, seg}, 32'hF9);
    step();
    chk("dp_an", {24'h0, an}, 32'hFE);
    chk("dp_seg", {24'h0, seg}, 32'h00);
    wr(2'd3, 32'h1);
    chk("blank_lag_an", {24'h0, an}, 32'hFE);
    step();
    chk("blank_an", {24'h0, an}, 32'hFF);
    chk("blank_seg", {24'h0, seg}, 32'hFF);
    wr(2'd3, 32'h0);

    // 4: VALUE written exactly on the wrap edge at 128
    run_to(127);
    wr(2'd0, 32'hAAAAAAAA);
    rd(2'd0, 32'hAAAAAAAA, "rb_value_a");
    step();
    chk("old_d0_seg", {24'h0, seg}, 32'h00);
    run_to(133);
    chk("old_d1_an", {24'h0, an}, 32'hFD);
    chk("old_d1_seg", {24'h0, seg}, 32'hF8);
    run_to(161);
    chk("new_d0_seg", {24'h0, seg}, 32'h08);
    run_to(165);
    chk("new_d1_an", {24'h0, an}, 32'hFD);
    chk("new_d1_seg", {24'h0, seg}, 32'h88);

    // 5: blink: dark while frame_cnt[4] = 1 (edges 513..1024)
    wr(2'd3, 32'h2);
    run_to(512);
    chk("blink_last_lit", {24'h0, an}, 32'h7F);
    step();
    chk("blink_off_an", {24'h0, an}, 32'hFF);
    rd(2'd3, 32'h82, "rb_ctrl_fc16");
    run_to(700);
    chk("blink_mid_an", {24'h0, an}, 32'hFF);
    run_to(1024);
    chk("blink_end_an", {24'h0, an}, 32'hFF);
    step();
    chk("blink_on_an", {24'h0, an}, 32'hFE);
    chk("blink_on_seg", {24'h0, seg}, 32'h08);
    rd(2'd3, 32'h02, "rb_ctrl_fc0");

    // 6: reset mid-frame at idx 5, with a write on the reset edge
    run_to(1045);
    rd(2'd3, 32'h52, "rb_idx5");
    chk("idx5_an", {24'h0, an}, 32'hDF);
    rst = 1'b1;
    seg_ena = 1'b1; wena = 1'b1; addr = 2'd0; data_in = 32'hFFFFFFFF;
    step();
    rst = 1'b0; seg_ena = 1'b0; wena = 1'b0;
    chk("mrst_an", {24'h0, an}, 32'hFF);
    chk("mrst_seg", {24'h0, seg}, 32'hFF);
    rd(2'd0, 32'h0, "mrst_value");
    rd(2'd1, 32'h0, "mrst_dp");
    rd(2'd2, 32'h0, "mrst_en");
    rd(2'd3, 32'h0, "mrst_ctrl");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
